// File: rtl/latch_drv_pkg.sv
// rtl/latch_drv_pkg.sv - shared types and limits for the latch gate driver
// Contents: sequence state enum, phase counter width, legal timing ranges,
// and the helper that turns a cycle count into a down-counter load value.
package latch_drv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        GATE  = 2'd2,
        HOLD  = 2'd3
    } state_e;

    localparam int CNT_W = 4;

    localparam int SETUP_MIN = 0;
    localparam int SETUP_MAX = 15;
    localparam int GATE_MIN  = 1;
    localparam int GATE_MAX  = 15;
    localparam int HOLD_MIN  = 0;
    localparam int HOLD_MAX  = 15;

    // A phase lasting n cycles loads n-1 so that it ends on the zero flag.
    function automatic logic [CNT_W-1:0] ld_val(input int n);
        if (n <= 0) begin
            return '0;
        end
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/latch_phase_counter.sv
// rtl/latch_phase_counter.sv - loadable down-counter timing each driver phase
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   load_i        : load load_val_i this edge (takes priority over counting)
//   load_val_i    : value to load
//   cnt_o         : current count
//   zero_o        : count has reached zero (counter holds at zero)
module latch_phase_counter
    import latch_drv_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/latch_gate_driver.sv
// rtl/latch_gate_driver.sv - drives data, gate, setup and hold for a transparent latch
// Optional build macro GATE_READBACK_EN adds lat_q / rb_err readback checking.
// Ports:
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   wr_valid, wr_ready : producer handshake (wr_ready is combinational)
//   wr_data            : word sampled only on the accept edge
//   lat_gate           : latch enable, transparent while high
//   lat_d              : latch data line, changes only on accept
//   busy               : write sequence in progress
//   done               : one-cycle pulse when a sequence completes
//   lat_q, rb_err      : (GATE_READBACK_EN) latch output and sticky mismatch flag
module latch_gate_driver
    import latch_drv_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int SETUP_CYC = 1,
    parameter int GATE_CYC  = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              lat_gate,
    output logic [DATA_W-1:0] lat_d,
    output logic              busy,
    output logic              done
`ifdef GATE_READBACK_EN
    ,
    input  logic [DATA_W-1:0] lat_q,
    output logic              rb_err
`endif
);

    if (SETUP_CYC < SETUP_MIN || SETUP_CYC > SETUP_MAX) begin : g_bad_setup
        $error("latch_gate_driver: SETUP_CYC out of range 0..15");
    end
    if (GATE_CYC < GATE_MIN || GATE_CYC > GATE_MAX) begin : g_bad_gate
        $error("latch_gate_driver: GATE_CYC out of range 1..15");
    end
    if (HOLD_CYC < HOLD_MIN || HOLD_CYC > HOLD_MAX) begin : g_bad_hold
        $error("latch_gate_driver: HOLD_CYC out of range 0..15");
    end

    localparam logic [CNT_W-1:0] SETUP_LD  = ld_val(SETUP_CYC);
    localparam logic [CNT_W-1:0] GATE_LD   = ld_val(GATE_CYC);
    localparam logic [CNT_W-1:0] HOLD_LD   = ld_val(HOLD_CYC);
    localparam bit               HAS_SETUP = (SETUP_CYC != 0);
    localparam bit               HAS_HOLD  = (HOLD_CYC != 0);

    state_e            state_q;
    state_e            state_d;
    logic              lat_gate_q;
    logic [DATA_W-1:0] lat_d_q;
    logic              busy_q;
    logic              done_q;

    logic              accept;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic [CNT_W-1:0]  cnt_val;
    logic              cnt_zero;

    assign wr_ready = (state_q == IDLE) && !reset;
    assign accept   = wr_valid && wr_ready;

    latch_phase_counter u_phase_cnt (
        .clock      (clock),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .cnt_o      (cnt_val),
        .zero_o     (cnt_zero)
    );

    // Every timed state is entered with its length minus one and exits on zero.
    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_load = 1'b1;
                    if (HAS_SETUP) begin
                        state_d      = SETUP;
                        cnt_load_val = SETUP_LD;
                    end else begin
                        state_d      = GATE;
                        cnt_load_val = GATE_LD;
                    end
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    state_d      = GATE;
                    cnt_load     = 1'b1;
                    cnt_load_val = GATE_LD;
                end
            end
            GATE: begin
                if (cnt_zero) begin
                    if (HAS_HOLD) begin
                        state_d      = HOLD;
                        cnt_load     = 1'b1;
                        cnt_load_val = HOLD_LD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            lat_gate_q <= 1'b0;
            lat_d_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_gate_q <= (state_d == GATE);
            busy_q     <= (state_d != IDLE);
            done_q     <= (state_q != IDLE) && (state_d == IDLE);
            if (accept) begin
                lat_d_q <= wr_data;
            end
        end
    end

    assign lat_gate = lat_gate_q;
    assign lat_d    = lat_d_q;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef GATE_READBACK_EN
    logic rb_err_q;
    logic rb_err_d;
    logic rb_check;

    // First cycle after the gate closes: first HOLD cycle, or the done cycle
    // when there is no hold window. lat_d still holds the written word here
    // even if a new accept happens on the same edge.
    always_comb begin
        rb_check = 1'b0;
        if (HAS_HOLD) begin
            rb_check = (state_q == HOLD) && (cnt_val == HOLD_LD);
        end else begin
            rb_check = done_q;
        end
        rb_err_d = (accept ? 1'b0 : rb_err_q) | (rb_check && (lat_q != lat_d_q));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rb_err_q <= 1'b0;
        end else begin
            rb_err_q <= rb_err_d;
        end
    end

    assign rb_err = rb_err_q;
`else
    logic unused_cnt;
    assign unused_cnt = ^cnt_val;
`endif

endmodule

// File: tb/tb_latch_gate_driver.sv
// tb/tb_latch_gate_driver.sv - self-checking bench for latch_gate_driver
module tb_latch_gate_driver;

    logic       clock = 1'b0;
    logic       reset = 1'b1;

    logic       valid_a = 1'b0;
    logic [7:0] data_a  = 8'h00;
    logic       ready_a, gate_a, busy_a, done_a;
    logic [7:0] latd_a;

    logic       valid_b = 1'b0;
    logic [7:0] data_b  = 8'h00;
    logic       ready_b, gate_b, busy_b, done_b;
    logic [7:0] latd_b;

`ifdef GATE_READBACK_EN
    logic [7:0] latq_a = 8'h00;
    logic [7:0] latq_b = 8'h00;
    logic       rberr_a, rberr_b;
`endif

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    logic [7:0] sb_a[$];
    logic [7:0] sb_b[$];
    int         rise_a[$];
    logic [7:0] exp_a, exp_b;
    logic       gate_a_prev = 1'b0;
    logic       gate_b_prev = 1'b0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc = cyc + 1;

    latch_gate_driver #(.DATA_W(8), .SETUP_CYC(1), .GATE_CYC(2), .HOLD_CYC(1)) dut_a (
        .clock    (clock),
        .reset    (reset),
        .wr_valid (valid_a),
        .wr_ready (ready_a),
        .wr_data  (data_a),
        .lat_gate (gate_a),
        .lat_d    (latd_a),
        .busy     (busy_a),
        .done     (done_a)
`ifdef GATE_READBACK_EN
        ,
        .lat_q    (latq_a),
        .rb_err   (rberr_a)
`endif
    );

    latch_gate_driver #(.DATA_W(8), .SETUP_CYC(0), .GATE_CYC(1), .HOLD_CYC(0)) dut_b (
        .clock    (clock),
        .reset    (reset),
        .wr_valid (valid_b),
        .wr_ready (ready_b),
        .wr_data  (data_b),
        .lat_gate (gate_b),
        .lat_d    (latd_b),
        .busy     (busy_b),
        .done     (done_b)
`ifdef GATE_READBACK_EN
        ,
        .lat_q    (latq_b),
        .rb_err   (rberr_b)
`endif
    );

    // Scoreboard: each accepted word must be on lat_d when the gate opens.
    always @(negedge clock) begin
        if (!reset && gate_a && !gate_a_prev) begin
            rise_a.push_back(cyc);
            vectors++;
            if (sb_a.size() == 0) begin
                miscompares++; $display("FAIL sb_a: unexpected gate pulse, lat_d=%h", latd_a);
            end else begin
                exp_a = sb_a.pop_front();
                if (latd_a !== exp_a) begin miscompares++; $display("FAIL sb_a lat_d at gate: got %h want %h", latd_a, exp_a); end
            end
        end
        if (!reset && gate_b && !gate_b_prev) begin
            vectors++;
            if (sb_b.size() == 0) begin
                miscompares++; $display("FAIL sb_b: unexpected gate pulse, lat_d=%h", latd_b);
            end else begin
                exp_b = sb_b.pop_front();
                if (latd_b !== exp_b) begin miscompares++; $display("FAIL sb_b lat_d at gate: got %h want %h", latd_b, exp_b); end
            end
        end
        gate_a_prev = gate_a;
        gate_b_prev = gate_b;
    end

    task automatic test_reset();
        reset = 1'b1; valid_a = 1'b1; data_a = 8'hEE; valid_b = 1'b1; data_b = 8'hEE;
        repeat (2) @(negedge clock);
        vectors++; if (gate_a !== 1'b0) begin miscompares++; $display("FAIL reset gate_a: got %b want 0", gate_a); end
        vectors++; if (latd_a !== 8'h00) begin miscompares++; $display("FAIL reset lat_d_a: got %h want 00", latd_a); end
        vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL reset busy_a: got %b want 0", busy_a); end
        vectors++; if (done_a !== 1'b0) begin miscompares++; $display("FAIL reset done_a: got %b want 0", done_a); end
        vectors++; if (ready_a !== 1'b0) begin miscompares++; $display("FAIL reset ready_a: got %b want 0", ready_a); end
        vectors++; if (ready_b !== 1'b0) begin miscompares++; $display("FAIL reset ready_b: got %b want 0", ready_b); end
        vectors++; if (gate_b !== 1'b0) begin miscompares++; $display("FAIL reset gate_b: got %b want 0", gate_b); end
        valid_a = 1'b0; valid_b = 1'b0; reset = 1'b0;
        @(negedge clock);
        vectors++; if (ready_a !== 1'b1) begin miscompares++; $display("FAIL post-reset ready_a: got %b want 1", ready_a); end
        vectors++; if (ready_b !== 1'b1) begin miscompares++; $display("FAIL post-reset ready_b: got %b want 1", ready_b); end
        vectors++; if (latd_a !== 8'h00) begin miscompares++; $display("FAIL post-reset lat_d_a: got %h want 00", latd_a); end
    endtask

    task automatic test_basic();
        logic [1:6] g_exp;
        logic [1:6] b_exp;
        logic [1:6] d_exp;
        logic [1:6] r_exp;
        g_exp = 6'b011000; b_exp = 6'b111100; d_exp = 6'b000010; r_exp = 6'b000011;
        valid_a = 1'b1; data_a = 8'hA5; sb_a.push_back(8'hA5);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (k == 1) valid_a = 1'b0;
            vectors++; if (latd_a !== 8'hA5) begin miscompares++; $display("FAIL basic lat_d c%0d: got %h want a5", k, latd_a); end
            vectors++; if (gate_a !== g_exp[k]) begin miscompares++; $display("FAIL basic gate c%0d: got %b want %b", k, gate_a, g_exp[k]); end
            vectors++; if (busy_a !== b_exp[k]) begin miscompares++; $display("FAIL basic busy c%0d: got %b want %b", k, busy_a, b_exp[k]); end
            vectors++; if (done_a !== d_exp[k]) begin miscompares++; $display("FAIL basic done c%0d: got %b want %b", k, done_a, d_exp[k]); end
            vectors++; if (ready_a !== r_exp[k]) begin miscompares++; $display("FAIL basic ready c%0d: got %b want %b", k, ready_a, r_exp[k]); end
        end
    endtask

    task automatic test_back_to_back();
        int r0;
        logic [7:0] want;
        r0 = rise_a.size();
        valid_a = 1'b1; data_a = 8'h3C; sb_a.push_back(8'h3C);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            want = (k <= 5) ? 8'h3C : 8'hC3;
            vectors++; if (latd_a !== want) begin miscompares++; $display("FAIL b2b lat_d c%0d: got %h want %h", k, latd_a, want); end
            if (k == 5) begin
                vectors++; if (ready_a !== 1'b1 || done_a !== 1'b1) begin miscompares++; $display("FAIL b2b done-cycle ready/done: got %b/%b want 1/1", ready_a, done_a); end
                data_a = 8'hC3; sb_a.push_back(8'hC3);
            end
            if (k == 6) begin
                vectors++; if (busy_a !== 1'b1) begin miscompares++; $display("FAIL b2b second busy: got %b want 1", busy_a); end
                valid_a = 1'b0;
            end
        end
        repeat (5) @(negedge clock);
        vectors++;
        if (rise_a.size() - r0 != 2) begin
            miscompares++; $display("FAIL b2b gate pulses: got %0d want 2", rise_a.size() - r0);
        end else if (rise_a[r0+1] - rise_a[r0] != 5) begin
            miscompares++; $display("FAIL b2b gate spacing: got %0d want 5", rise_a[r0+1] - rise_a[r0]);
        end
        vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL b2b final busy: got %b want 0", busy_a); end
    endtask

    task automatic test_fast_params();
        valid_b = 1'b1; data_b = 8'h5A; sb_b.push_back(8'h5A);
`ifdef GATE_READBACK_EN
        latq_b = 8'h5A;
`endif
        @(negedge clock);
        valid_b = 1'b0;
        vectors++; if (gate_b !== 1'b1) begin miscompares++; $display("FAIL fast gate c1: got %b want 1", gate_b); end
        vectors++; if (busy_b !== 1'b1) begin miscompares++; $display("FAIL fast busy c1: got %b want 1", busy_b); end
        vectors++; if (done_b !== 1'b0) begin miscompares++; $display("FAIL fast done c1: got %b want 0", done_b); end
        vectors++; if (latd_b !== 8'h5A) begin miscompares++; $display("FAIL fast lat_d c1: got %h want 5a", latd_b); end
        @(negedge clock);
        vectors++; if (gate_b !== 1'b0) begin miscompares++; $display("FAIL fast gate c2: got %b want 0", gate_b); end
        vectors++; if (done_b !== 1'b1) begin miscompares++; $display("FAIL fast done c2: got %b want 1", done_b); end
        vectors++; if (ready_b !== 1'b1) begin miscompares++; $display("FAIL fast ready c2: got %b want 1", ready_b); end
        @(negedge clock);
        vectors++; if (done_b !== 1'b0) begin miscompares++; $display("FAIL fast done c3: got %b want 0", done_b); end
    endtask

    task automatic test_reset_mid();
        valid_a = 1'b1; data_a = 8'hFF; sb_a.push_back(8'hFF);
        @(negedge clock); valid_a = 1'b0;
        @(negedge clock);
        @(negedge clock);
        vectors++; if (gate_a !== 1'b1) begin miscompares++; $display("FAIL rstmid second gate cycle: got %b want 1", gate_a); end
        reset = 1'b1;
        @(negedge clock);
        vectors++; if (gate_a !== 1'b0) begin miscompares++; $display("FAIL rstmid gate: got %b want 0", gate_a); end
        vectors++; if (latd_a !== 8'h00) begin miscompares++; $display("FAIL rstmid lat_d: got %h want 00", latd_a); end
        vectors++; if (done_a !== 1'b0) begin miscompares++; $display("FAIL rstmid done: got %b want 0", done_a); end
        vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL rstmid busy: got %b want 0", busy_a); end
        vectors++; if (ready_a !== 1'b0) begin miscompares++; $display("FAIL rstmid ready in reset: got %b want 0", ready_a); end
        reset = 1'b0;
        #1;
        vectors++; if (ready_a !== 1'b1) begin miscompares++; $display("FAIL rstmid ready after release: got %b want 1", ready_a); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            vectors++; if (done_a !== 1'b0 || gate_a !== 1'b0) begin miscompares++; $display("FAIL rstmid idle done/gate: got %b/%b want 0/0", done_a, gate_a); end
        end
    endtask

    task automatic test_data_toggle();
        valid_a = 1'b1; data_a = 8'h11; sb_a.push_back(8'h11);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            vectors++; if (latd_a !== 8'h11) begin miscompares++; $display("FAIL toggle lat_d c%0d: got %h want 11", k, latd_a); end
            if (k <= 4) begin
                data_a = (k % 2 == 1) ? 8'h22 : 8'h11;
            end else if (k == 5) begin
                vectors++; if (done_a !== 1'b1) begin miscompares++; $display("FAIL toggle done c5: got %b want 1", done_a); end
                valid_a = 1'b0;
            end else begin
                vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL toggle extra accept busy: got %b want 0", busy_a); end
            end
        end
        repeat (2) @(negedge clock);
    endtask

`ifdef GATE_READBACK_EN
    task automatic test_readback();
        valid_a = 1'b1; data_a = 8'h5A; latq_a = 8'h5B; sb_a.push_back(8'h5A);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (k == 1) valid_a = 1'b0;
            if (k == 4) begin
                vectors++; if (rberr_a !== 1'b0) begin miscompares++; $display("FAIL rb before compare: got %b want 0", rberr_a); end
            end
            if (k >= 5 && k <= 7) begin
                vectors++; if (rberr_a !== 1'b1) begin miscompares++; $display("FAIL rb sticky c%0d: got %b want 1", k, rberr_a); end
            end
            if (k == 7) begin
                valid_a = 1'b1; data_a = 8'hC4; latq_a = 8'hC4; sb_a.push_back(8'hC4);
            end
            if (k == 8) begin
                valid_a = 1'b0;
                vectors++; if (rberr_a !== 1'b0) begin miscompares++; $display("FAIL rb clear on accept: got %b want 0", rberr_a); end
            end
        end
        repeat (5) @(negedge clock);
        vectors++; if (rberr_a !== 1'b0) begin miscompares++; $display("FAIL rb matching write: got %b want 0", rberr_a); end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_fast_params();
        test_reset_mid();
        test_data_toggle();
`ifdef GATE_READBACK_EN
        test_readback();
`endif
        @(negedge clock);
        vectors++; if (sb_a.size() != 0) begin miscompares++; $display("FAIL sb_a leftover words: got %0d want 0", sb_a.size()); end
        vectors++; if (sb_b.size() != 0) begin miscompares++; $display("FAIL sb_b leftover words: got %0d want 0", sb_b.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
